// File: rtl/pipe_pkg.sv
// Shared definitions for the 8-bit pipeline.
//   ADDR_W / INSTR_W : address and instruction widths
//   OP_JMP           : opcode decoded as an absolute jump
//   fetch_state_e    : fetch FSM encoding (RUN, REDIRECT)
//   fetch_entry_t    : one instruction-buffer slot {instr, pc}
package pipe_pkg;
  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 8;
  localparam logic [1:0] OP_JMP = 2'b11;

  typedef enum logic {
    FS_RUN      = 1'b0,
    FS_REDIRECT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, the
// valid/ready hand-off to decode, and the redirect from decode.
//   master : fetch_unit side
//   slave  : environment side (memory + decode)
interface fetch_unit_if;
  import pipe_pkg::*;

  logic               imem_rd_en;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               if_valid;
  logic [INSTR_W-1:0] if_instr;
  logic [ADDR_W-1:0]  if_pc;
  logic               id_ready;
  logic               jmp_valid;
  logic [ADDR_W-1:0]  jmp_addr;

  modport master (
    output imem_rd_en, imem_addr, if_valid, if_instr, if_pc,
    input  imem_rdata, id_ready, jmp_valid, jmp_addr
  );

  modport slave (
    input  imem_rd_en, imem_addr, if_valid, if_instr, if_pc,
    output imem_rdata, id_ready, jmp_valid, jmp_addr
  );
endinterface

// File: rtl/fetch_buffer.sv
// Two-entry synchronous FIFO of {instr, pc}.
//   clk, rst_n : clock, async active-low reset
//   push/wdata : write at tail
//   pop/rdata  : head entry and advance
//   flush      : empty the FIFO; wins over a same-cycle push
//   occ        : entries held (0..2)
module fetch_buffer
  import pipe_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t wdata,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t rdata,
  output logic [1:0]   occ
);
  fetch_entry_t [1:0] mem_q, mem_d;
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [1:0]         occ_q, occ_d;
  logic               do_push, do_pop;

  always_comb begin
    do_pop   = pop && (occ_q != 2'd0);
    // A full buffer can still take a push when the head leaves this cycle.
    do_push  = push && ((occ_q != 2'd2) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      occ_d    = 2'd0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_d = ~rd_ptr_q;
      occ_d = occ_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign occ   = occ_q;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues reads to a synchronous
// instruction memory (1-cycle latency), queues returned instructions in a
// 2-entry buffer and presents them to decode over valid/ready. A jump pulse
// from decode redirects the PC and squashes everything on the wrong path.
//   clk, rst_n : clock, async active-low reset
//   bus        : fetch_unit_if.master (imem_*, if_*, id_ready, jmp_*)
//   RESET_PC   : PC after reset
module fetch_unit
  import pipe_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);
  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;

  logic [1:0]   occ;
  fetch_entry_t head, cap_entry;
  logic         pop, issue, capture, flush;
  logic [2:0]   need;

  always_comb begin
    pop     = (occ != 2'd0) && bus.id_ready;
    // Slots that will be spoken for after this cycle if nothing new issues.
    need    = {1'b0, occ} + {2'b0, inflight_q} - {2'b0, pop};
    state_d = state_q;
    pc_d    = pc_q;
    issue   = 1'b0;
    capture = 1'b0;
    flush   = 1'b0;
    case (state_q)
      FS_RUN: begin
        if (bus.jmp_valid) begin
          // Jump overrides issue/capture; the data landing now is wrong-path.
          pc_d    = bus.jmp_addr;
          flush   = 1'b1;
          state_d = FS_REDIRECT;
        end else begin
          issue   = (need <= 3'd1);
          capture = inflight_q;
        end
      end
      FS_REDIRECT: begin
        // Buffer is empty and nothing useful is in flight: always refetch.
        issue   = 1'b1;
        state_d = FS_RUN;
      end
      default: state_d = FS_RUN;
    endcase
    if (issue) pc_d = pc_q + 8'd1;
    inflight_d    = issue;
    inflight_pc_d = issue ? pc_q : inflight_pc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FS_RUN;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  always_comb begin
    cap_entry.instr = bus.imem_rdata;
    cap_entry.pc    = inflight_pc_q;
  end

  fetch_buffer u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (capture),
    .wdata (cap_entry),
    .pop   (pop),
    .flush (flush),
    .rdata (head),
    .occ   (occ)
  );

  // Gated by rst_n so no request leaks out while reset is held.
  assign bus.imem_rd_en = issue & rst_n;
  assign bus.imem_addr  = pc_q;
  assign bus.if_valid   = (occ != 2'd0);
  assign bus.if_instr   = head.instr;
  assign bus.if_pc      = head.pc;
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. Memory returns addr ^ 8'hA5 one cycle
// after a request (random garbage otherwise). Inputs change and outputs are
// sampled just after the falling edge.
module tb_fetch_unit;
  import pipe_pkg::*;

  localparam logic [7:0] RST_PC = 8'h00;
  localparam logic [7:0] XORK   = 8'hA5;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int checks   = 0;
  int failures = 0;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    bus.imem_rdata <= bus.imem_rd_en ? (bus.imem_addr ^ XORK) : 8'($urandom);

  task automatic cyc();
    @(negedge clk); #1;
  endtask

  // Leaves the bench in cycle 0 after reset release (before its rising edge).
  task automatic do_reset();
    bus.id_ready  = 1'b0;
    bus.jmp_valid = 1'b0;
    bus.jmp_addr  = 8'h00;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.id_ready  = 1'b1;
    bus.jmp_valid = 1'b0;
    bus.jmp_addr  = 8'h00;
    #1 rst_n = 1'b0;
    cyc();
    checks++;
    if ({bus.if_valid, bus.imem_rd_en} !== 2'b00) begin
      failures++;
      $display("FAIL reset_ctl got valid=%b rd_en=%b exp 0 0", bus.if_valid, bus.imem_rd_en);
    end
    checks++;
    if ({bus.if_instr, bus.if_pc} !== 16'h0000) begin
      failures++;
      $display("FAIL reset_data got instr=%h pc=%h exp 00 00", bus.if_instr, bus.if_pc);
    end
  endtask

  task automatic test_sequential();
    logic [7:0] e;
    do_reset();
    bus.id_ready = 1'b1;
    #1;
    checks++;
    if ({bus.imem_rd_en, bus.imem_addr, bus.if_valid} !== {1'b1, RST_PC, 1'b0}) begin
      failures++;
      $display("FAIL seq_c0 got rd_en=%b addr=%h valid=%b exp 1 %h 0",
               bus.imem_rd_en, bus.imem_addr, bus.if_valid, RST_PC);
    end
    cyc();
    checks++;
    if (bus.if_valid !== 1'b0) begin
      failures++;
      $display("FAIL seq_c1 got valid=%b exp 0", bus.if_valid);
    end
    e = RST_PC;
    for (int k = 0; k < 4; k++) begin
      cyc();
      checks++;
      if ({bus.if_valid, bus.if_pc, bus.if_instr} !== {1'b1, e, e ^ XORK}) begin
        failures++;
        $display("FAIL seq_pop k=%0d got valid=%b pc=%h instr=%h exp pc=%h instr=%h",
                 k, bus.if_valid, bus.if_pc, bus.if_instr, e, e ^ XORK);
      end
      e = e + 8'd1;
    end
  endtask

  task automatic test_stall();
    logic [7:0] e;
    int got, n;
    do_reset();
    bus.id_ready = 1'b0;
    cyc();
    cyc();
    for (int s = 0; s < 5; s++) begin
      if (s > 0) cyc();
      checks++;
      if ({bus.if_valid, bus.if_pc, bus.imem_rd_en} !== {1'b1, RST_PC, 1'b0}) begin
        failures++;
        $display("FAIL stall_hold s=%0d got valid=%b pc=%h rd_en=%b exp 1 %h 0",
                 s, bus.if_valid, bus.if_pc, bus.imem_rd_en, RST_PC);
      end
    end
    bus.id_ready = 1'b1;
    e = RST_PC;
    got = 0;
    n = 0;
    while (got < 6 && n < 20) begin
      if (bus.if_valid) begin
        checks++;
        if ({bus.if_pc, bus.if_instr} !== {e, e ^ XORK}) begin
          failures++;
          $display("FAIL stall_order got pc=%h instr=%h exp pc=%h instr=%h",
                   bus.if_pc, bus.if_instr, e, e ^ XORK);
        end
        e = e + 8'd1;
        got++;
      end
      n++;
      cyc();
    end
    checks++;
    if (got != 6 || n != 6) begin
      failures++;
      $display("FAIL stall_release got pops=%0d cycles=%0d exp 6 6", got, n);
    end
  endtask

  // Waits out the two-cycle bubble after a jump issued in the current cycle
  // and checks that the redirected stream starts at target.
  task automatic test_jump_seq(input logic [7:0] target, input int npops, input string tag);
    logic [7:0] e;
    bus.jmp_valid = 1'b1;
    bus.jmp_addr  = target;
    #1;
    checks++;
    if (bus.imem_rd_en !== 1'b0) begin
      failures++;
      $display("FAIL %s_jcyc got rd_en=%b exp 0", tag, bus.imem_rd_en);
    end
    cyc();
    bus.jmp_valid = 1'b0;
    bus.jmp_addr  = 8'($urandom);
    #1;
    checks++;
    if ({bus.if_valid, bus.imem_rd_en, bus.imem_addr} !== {1'b0, 1'b1, target}) begin
      failures++;
      $display("FAIL %s_j1 got valid=%b rd_en=%b addr=%h exp 0 1 %h",
               tag, bus.if_valid, bus.imem_rd_en, bus.imem_addr, target);
    end
    cyc();
    checks++;
    if (bus.if_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_j2 got valid=%b exp 0", tag, bus.if_valid);
    end
    e = target;
    for (int k = 0; k < npops; k++) begin
      cyc();
      checks++;
      if ({bus.if_valid, bus.if_pc, bus.if_instr} !== {1'b1, e, e ^ XORK}) begin
        failures++;
        $display("FAIL %s_pop k=%0d got valid=%b pc=%h instr=%h exp pc=%h",
                 tag, k, bus.if_valid, bus.if_pc, bus.if_instr, e);
      end
      e = e + 8'd1;
    end
  endtask

  task automatic test_jump();
    do_reset();
    bus.id_ready = 1'b1;
    cyc();
    for (int k = 0; k < 4; k++) begin
      cyc();
      checks++;
      if ({bus.if_valid, bus.if_pc} !== {1'b1, 8'(k)}) begin
        failures++;
        $display("FAIL jump_pre k=%0d got valid=%b pc=%h exp 1 %h",
                 k, bus.if_valid, bus.if_pc, 8'(k));
      end
    end
    // Popping pc 03 is the jump itself.
    test_jump_seq(8'hE0, 2, "jump");
  endtask

  task automatic test_wrap();
    do_reset();
    bus.id_ready = 1'b1;
    cyc();
    cyc();
    test_jump_seq(8'hFE, 4, "wrap");
  endtask

  task automatic test_jump_full();
    do_reset();
    bus.id_ready = 1'b0;
    repeat (3) cyc();
    checks++;
    if ({bus.if_valid, bus.if_pc, bus.imem_rd_en} !== {1'b1, RST_PC, 1'b0}) begin
      failures++;
      $display("FAIL full_pre got valid=%b pc=%h rd_en=%b exp 1 %h 0",
               bus.if_valid, bus.if_pc, bus.imem_rd_en, RST_PC);
    end
    // Pop the head of the full buffer: a new fetch goes in flight.
    bus.id_ready = 1'b1;
    #1;
    checks++;
    if (bus.imem_rd_en !== 1'b1) begin
      failures++;
      $display("FAIL full_refill got rd_en=%b exp 1", bus.imem_rd_en);
    end
    cyc();
    checks++;
    if ({bus.if_valid, bus.if_pc} !== {1'b1, RST_PC + 8'd1}) begin
      failures++;
      $display("FAIL full_head got valid=%b pc=%h exp 1 %h",
               bus.if_valid, bus.if_pc, RST_PC + 8'd1);
    end
    test_jump_seq(8'h1F, 2, "full");
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.id_ready = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.if_valid, bus.imem_rd_en} !== 2'b00) begin
      failures++;
      $display("FAIL midrst_async got valid=%b rd_en=%b exp 0 0", bus.if_valid, bus.imem_rd_en);
    end
    @(negedge clk);
    #1 rst_n = 1'b1;
    bus.id_ready = 1'b1;
    #1;
    checks++;
    if ({bus.imem_rd_en, bus.imem_addr, bus.if_valid} !== {1'b1, RST_PC, 1'b0}) begin
      failures++;
      $display("FAIL midrst_c0 got rd_en=%b addr=%h valid=%b exp 1 %h 0",
               bus.imem_rd_en, bus.imem_addr, bus.if_valid, RST_PC);
    end
    cyc();
    for (int k = 0; k < 2; k++) begin
      cyc();
      checks++;
      if ({bus.if_valid, bus.if_pc} !== {1'b1, RST_PC + 8'(k)}) begin
        failures++;
        $display("FAIL midrst_pop k=%0d got valid=%b pc=%h exp 1 %h",
                 k, bus.if_valid, bus.if_pc, RST_PC + 8'(k));
      end
    end
  endtask

  // Random ready/jump traffic against a stream model: the delivered pcs are
  // consecutive, restarting at the target after each jump, with a fixed
  // two-cycle bubble after every jump and no other long bubbles.
  task automatic test_random();
    logic [7:0] exp_pc;
    logic rdy, jmp;
    int j_age, low_run;
    do_reset();
    exp_pc  = RST_PC;
    j_age   = 0;
    low_run = 0;
    for (int c = 0; c < 400; c++) begin
      if (c > 0) cyc();
      if (j_age != 0) begin
        checks++;
        if (bus.if_valid !== (j_age == 3)) begin
          failures++;
          $display("FAIL rnd_bubble c=%0d age=%0d got valid=%b", c, j_age, bus.if_valid);
        end
        j_age = (j_age == 3) ? 0 : j_age + 1;
      end
      low_run = bus.if_valid ? 0 : low_run + 1;
      checks++;
      if (low_run > 2) begin
        failures++;
        $display("FAIL rnd_starve c=%0d got low_run=%0d exp <=2", c, low_run);
      end
      rdy = ($urandom_range(0, 99) < 70);
      jmp = bus.if_valid && rdy && ($urandom_range(0, 9) == 0);
      bus.id_ready  = rdy;
      bus.jmp_valid = jmp;
      bus.jmp_addr  = 8'($urandom);
      if (bus.if_valid && rdy) begin
        checks++;
        if ({bus.if_pc, bus.if_instr} !== {exp_pc, exp_pc ^ XORK}) begin
          failures++;
          $display("FAIL rnd_pop c=%0d got pc=%h instr=%h exp pc=%h instr=%h",
                   c, bus.if_pc, bus.if_instr, exp_pc, exp_pc ^ XORK);
        end
        exp_pc = jmp ? bus.jmp_addr : exp_pc + 8'd1;
      end
      if (jmp) begin
        #1;
        checks++;
        if (bus.imem_rd_en !== 1'b0) begin
          failures++;
          $display("FAIL rnd_jrd c=%0d got rd_en=%b exp 0", c, bus.imem_rd_en);
        end
        j_age = 1;
      end
    end
    bus.jmp_valid = 1'b0;
  endtask

  initial begin
    bus.id_ready  = 1'b0;
    bus.jmp_valid = 1'b0;
    bus.jmp_addr  = 8'h00;
    test_reset();
    test_sequential();
    test_stall();
    test_jump();
    test_wrap();
    test_jump_full();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
